// File: rtl/vga_rx_monitor.sv
// vga_rx_monitor: recovers active-pixel coordinates from a sampled VGA stream, checks line/frame timing, captures one probe pixel.
// Outputs register 1 Clk after each pix_en sample, never stalls the source; VGA_MON_CRC_EN adds a per-frame CRC-16-CCITT.
module vga_rx_monitor #(
  parameter int   H_TOTAL  = 800,
  parameter int   V_TOTAL  = 525,
  parameter int   H_BP     = 144,
  parameter int   H_ACTIVE = 640,
  parameter int   V_BP     = 35,
  parameter int   V_ACTIVE = 480,
  parameter logic SYNC_POL = 1'b0
) (
  input  logic        Clk,
  input  logic        Reset_n,
  input  logic        pix_en,
  input  logic        hSync,
  input  logic        vSync,
  input  logic [3:0]  vgaR,
  input  logic [3:0]  vgaG,
  input  logic [3:0]  vgaB,
  input  logic [9:0]  probe_x,
  input  logic [9:0]  probe_y,
  output logic [9:0]  x_coord,
  output logic [9:0]  y_coord,
  output logic        active,
  output logic        locked,
  output logic        line_err,
  output logic        frame_err,
  output logic [7:0]  err_count,
  output logic [15:0] frame_count,
  output logic [11:0] probe_rgb,
  output logic        probe_valid,
  output logic [15:0] frame_crc,
  output logic        crc_valid
);
  typedef enum logic [1:0] {SEARCH, ACQUIRE, LOCKED} monState;

  localparam logic [9:0] H_LO = 10'(H_BP);
  localparam logic [9:0] H_HI = 10'(H_BP + H_ACTIVE);
  localparam logic [9:0] V_LO = 10'(V_BP);
  localparam logic [9:0] V_HI = 10'(V_BP + V_ACTIVE);

  monState     state, stateNext;
  logic        errSeen, errSeenNext;
  logic [9:0]  hCount, vCount, hNext, vNext, vUpd;
  logic        prevHs, prevVs;
  logic        hsAsserted, vsAsserted, hEdge, vStart;
  logic        lineBad, frameBad, anyErr, sampleActive, probeHit;
  logic [11:0] pixRgb;

  function automatic logic inWin(input logic [9:0] h, input logic [9:0] v);
    return (h >= H_LO) && (h < H_HI) && (v >= V_LO) && (v < V_HI);
  endfunction

  assign pixRgb     = {vgaR, vgaG, vgaB};
  assign hsAsserted = (hSync == SYNC_POL);
  assign vsAsserted = (vSync == SYNC_POL);
  assign hEdge      = pix_en && hsAsserted && !prevHs;
  // Vertical state is only meaningful at line starts, so vSync is judged there.
  assign vStart     = hEdge && vsAsserted && !prevVs;
  assign lineBad    = hEdge && (state != SEARCH) && (({1'b0, hCount} + 11'd1) != 11'(H_TOTAL));
  assign frameBad   = vStart && (state != SEARCH) && (({1'b0, vCount} + 11'd1) != 11'(V_TOTAL));
  assign anyErr     = lineBad || frameBad;

  assign hNext = hEdge ? 10'd0 : ((hCount == 10'h3FF) ? hCount : hCount + 10'd1);
  assign vNext = vStart ? 10'd0 : ((vCount == 10'h3FF) ? vCount : vCount + 10'd1);
  assign vUpd  = hEdge ? vNext : vCount;

  // State only changes at a line start, where hNext is outside the window.
  assign sampleActive = pix_en && (state == LOCKED) && inWin(hNext, vUpd);
  assign probeHit     = sampleActive && ((hNext - H_LO) == probe_x) && ((vUpd - V_LO) == probe_y);

  assign locked  = (state == LOCKED);
  assign active  = locked && inWin(hCount, vCount);
  assign x_coord = active ? hCount - H_LO : 10'd0;
  assign y_coord = active ? vCount - V_LO : 10'd0;

  always_comb begin
    stateNext   = state;
    errSeenNext = errSeen;
    case (state)
      SEARCH: begin
        if (vStart) begin
          stateNext   = ACQUIRE;
          errSeenNext = 1'b0;
        end
      end
      ACQUIRE: begin
        if (vStart) begin
          stateNext   = (errSeen || anyErr) ? ACQUIRE : LOCKED;
          errSeenNext = 1'b0;
        end else if (anyErr) begin
          errSeenNext = 1'b1;
        end
      end
      LOCKED: begin
        if (anyErr) stateNext = SEARCH;
      end
      default: stateNext = SEARCH;
    endcase
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state       <= SEARCH;
      errSeen     <= 1'b0;
      hCount      <= 10'd0;
      vCount      <= 10'd0;
      prevHs      <= 1'b0;
      prevVs      <= 1'b0;
      line_err    <= 1'b0;
      frame_err   <= 1'b0;
      err_count   <= 8'd0;
      frame_count <= 16'd0;
      probe_rgb   <= 12'd0;
      probe_valid <= 1'b0;
    end else begin
      state       <= stateNext;
      errSeen     <= errSeenNext;
      line_err    <= lineBad;
      frame_err   <= frameBad;
      probe_valid <= probeHit;
      if (pix_en) begin
        prevHs <= hsAsserted;
        hCount <= hNext;
      end
      if (hEdge) begin
        prevVs <= vsAsserted;
        vCount <= vNext;
      end
      if (anyErr && (err_count != 8'hFF)) err_count <= err_count + 8'd1;
      if (vStart && (state == LOCKED)) frame_count <= frame_count + 16'd1;
      if (probeHit) probe_rgb <= pixRgb;
    end
  end

`ifdef VGA_MON_CRC_EN
  logic [15:0] crcAcc;

  function automatic logic [15:0] crcStep(input logic [15:0] c, input logic [11:0] d);
    logic [15:0] r;
    r = c;
    for (int i = 11; i >= 0; i--) begin
      r = {r[14:0], 1'b0} ^ ((r[15] ^ d[i]) ? 16'h1021 : 16'h0000);
    end
    return r;
  endfunction

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      crcAcc    <= 16'hFFFF;
      frame_crc <= 16'd0;
      crc_valid <= 1'b0;
    end else begin
      crc_valid <= vStart && (state == LOCKED);
      if (vStart) begin
        crcAcc <= 16'hFFFF;
        if (state == LOCKED) frame_crc <= crcAcc;
      end else if (sampleActive) begin
        crcAcc <= crcStep(crcAcc, pixRgb);
      end
    end
  end
`else
  assign frame_crc = 16'd0;
  assign crc_valid = 1'b0;
`endif

endmodule

// File: tb/tb_vga_rx_monitor.sv
// Randomized raster stream against a sample-level behavioural model of the monitor, on a shrunken timing format.
module tb_vga_rx_monitor;
  localparam int TH = 20, TV = 12, TBP = 5, TA = 12, TVBP = 3, TVA = 7;
  localparam int PX = 6, PY = 3;

  logic        Clk = 1'b0;
  logic        Reset_n = 1'b1;
  logic        pix_en = 1'b0, hSync = 1'b1, vSync = 1'b1;
  logic [3:0]  vgaR = 4'd0, vgaG = 4'd0, vgaB = 4'd0;
  logic [9:0]  probe_x = 10'd0, probe_y = 10'd0;
  logic [9:0]  x_coord, y_coord;
  logic        active, locked, line_err, frame_err, probe_valid, crc_valid;
  logic [7:0]  err_count;
  logic [15:0] frame_count, frame_crc;
  logic [11:0] probe_rgb;

  vga_rx_monitor #(.H_TOTAL(TH), .V_TOTAL(TV), .H_BP(TBP), .H_ACTIVE(TA), .V_BP(TVBP),
                   .V_ACTIVE(TVA), .SYNC_POL(1'b0)) dut (
    .Clk(Clk), .Reset_n(Reset_n), .pix_en(pix_en), .hSync(hSync), .vSync(vSync),
    .vgaR(vgaR), .vgaG(vgaG), .vgaB(vgaB), .probe_x(probe_x), .probe_y(probe_y),
    .x_coord(x_coord), .y_coord(y_coord), .active(active), .locked(locked),
    .line_err(line_err), .frame_err(frame_err), .err_count(err_count), .frame_count(frame_count),
    .probe_rgb(probe_rgb), .probe_valid(probe_valid), .frame_crc(frame_crc), .crc_valid(crc_valid));

  initial forever #5 Clk = ~Clk;

  int nTests = 0, nFail = 0;
  bit chkOn = 0, pinLock = 0, pinXY = 0;
  int pvCount = 0, leCount = 0, feCount = 0;
  logic [15:0] crcQ[$];

  // Model state: position within line/frame, lock phase (0 search, 1 acquire, 2 locked).
  int mH, mV, mState, mErrCnt, mFc;
  bit mPrevHs, mPrevVs, mErrSeen;
  logic [11:0] mProbe;
  logic [15:0] mCrc, mFcrc;
  bit eLE, eFE, ePV, eCV;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nTests++;
    if (act !== exp) begin
      nFail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [15:0] crc12(input logic [15:0] c, input logic [11:0] d);
    logic [15:0] r;
    bit fb;
    r = c;
    for (int i = 11; i >= 0; i--) begin
      fb = r[15] ^ d[i];
      r = {r[14:0], 1'b0};
      if (fb) r = r ^ 16'h1021;
    end
    return r;
  endfunction

  function automatic bit mActive();
    return mState == 2 && mH >= TBP && mH < TBP + TA && mV >= TVBP && mV < TVBP + TVA;
  endfunction

  task automatic modelReset();
    mH = 0; mV = 0; mState = 0; mErrCnt = 0; mFc = 0;
    mPrevHs = 0; mPrevVs = 0; mErrSeen = 0;
    mProbe = 12'd0; mCrc = 16'hFFFF; mFcrc = 16'd0;
    eLE = 0; eFE = 0; ePV = 0; eCV = 0;
  endtask

  task automatic modelStep(input bit hsA, input bit vsA, input logic [11:0] rgb,
                           input logic [9:0] px, input logic [9:0] py);
    bit edgeH, vst, err;
    int wasState;
    edgeH = hsA && !mPrevHs;
    mPrevHs = hsA;
    vst = 0;
    wasState = mState;
    if (!edgeH) mH = (mH < 1023) ? mH + 1 : 1023;
    else begin
      eLE = (mH + 1 != TH) && mState != 0;
      vst = vsA && !mPrevVs;
      mPrevVs = vsA;
      if (vst) eFE = (mV + 1 != TV) && mState != 0;
      mV = vst ? 0 : ((mV < 1023) ? mV + 1 : 1023);
      mH = 0;
    end
    err = eLE || eFE;
    if (err && mErrCnt < 255) mErrCnt++;
    if (vst && mState == 2) mFc = (mFc + 1) % 65536;
    if (mState == 1 && err) mErrSeen = 1;
    if (vst) begin
      if (mState == 0) mState = 1;
      else if (mState == 1) mState = mErrSeen ? 1 : 2;
      mErrSeen = 0;
    end
    if (mState == 2 && err) mState = 0;
`ifdef VGA_MON_CRC_EN
    if (vst) begin
      if (wasState == 2) begin mFcrc = mCrc; eCV = 1; end
      mCrc = 16'hFFFF;
    end
`endif
    if (mActive()) begin
      if (mH - TBP == int'(px) && mV - TVBP == int'(py)) begin mProbe = rgb; ePV = 1; end
`ifdef VGA_MON_CRC_EN
      mCrc = crc12(mCrc, rgb);
`endif
    end
  endtask

  always @(negedge Clk) begin
    if (chkOn) begin
      chk("active", active, mActive());
      chk("x_coord", x_coord, mActive() ? mH - TBP : 0);
      chk("y_coord", y_coord, mActive() ? mV - TVBP : 0);
      chk("locked", locked, mState == 2);
      chk("line_err", line_err, eLE);
      chk("frame_err", frame_err, eFE);
      chk("err_count", err_count, mErrCnt);
      chk("frame_count", frame_count, mFc);
      chk("probe_rgb", probe_rgb, mProbe);
      chk("probe_valid", probe_valid, ePV);
      chk("frame_crc", frame_crc, mFcrc);
      chk("crc_valid", crc_valid, eCV);
      if (probe_valid) pvCount++;
      if (line_err) leCount++;
      if (frame_err) feCount++;
      if (crc_valid) crcQ.push_back(frame_crc);
    end
  end

  task automatic tick(input bit pe, input bit hsA, input bit vsA, input logic [11:0] rgb,
                      input logic [9:0] px, input logic [9:0] py);
    @(negedge Clk);
    pix_en = pe; hSync = ~hsA; vSync = ~vsA;
    {vgaR, vgaG, vgaB} = rgb;
    probe_x = px; probe_y = py;
    @(posedge Clk);
    eLE = 0; eFE = 0; ePV = 0; eCV = 0;
    if (pe && Reset_n) modelStep(hsA, vsA, rgb, px, py);
  endtask

  task automatic idleTick();
    tick(1'b0, 1'($urandom), 1'($urandom), 12'($urandom), 10'($urandom), 10'($urandom));
  endtask

  task automatic sample(input bit hsA, input bit vsA, input logic [11:0] rgb,
                        input logic [9:0] px, input logic [9:0] py);
    int gaps;
    gaps = $urandom_range(0, 2);
    for (int i = 0; i < gaps; i++) idleTick();
    tick(1'b1, hsA, vsA, rgb, px, py);
  endtask

  // Pixels [p0, p1) of one line; mode 0 random, 1 probe marker, 2 fixed pattern, 3 pattern with one flipped pixel.
  task automatic sendLine(input int line, input int p0, input int p1, input int mode);
    for (int p = p0; p < p1; p++) begin
      int x, y;
      logic [11:0] c;
      logic [9:0] px, py;
      x = p - TBP; y = line - TVBP;
      px = 10'(PX); py = 10'(PY);
      case (mode)
        0: begin
          c = 12'($urandom);
          px = 10'($urandom_range(0, TA - 1));
          py = 10'($urandom_range(0, TVA - 1));
        end
        1: c = (x == PX && y == PY) ? 12'hF00 : 12'h000;
        default: begin
          c = 12'(x * 37 + y * 101 + 5);
          if (mode == 3 && x == 2 && y == 2) c = c ^ 12'h001;
        end
      endcase
      sample(p < 3, line < 2, c, px, py);
      if (pinLock && line == 0 && p == 0) begin #1; chk("locked_after_2nd_vstart", locked, 1); end
      if (pinXY && line == TVBP && p == TBP) begin
        #1;
        chk("first_px_active", active, 1);
        chk("first_px_x", x_coord, 0);
        chk("first_px_y", y_coord, 0);
      end
      if (pinXY && line == TVBP + TVA - 1 && p == TBP + TA - 1) begin
        #1;
        chk("last_px_x", x_coord, 11);
        chk("last_px_y", y_coord, 6);
      end
    end
  endtask

  task automatic sendFrame(input int nLines, input int shortLine, input int mode);
    for (int l = 0; l < nLines; l++) sendLine(l, 0, (l == shortLine) ? TH - 1 : TH, mode);
  endtask

  task automatic chkAllZero(input string tag);
    chk({tag, "_x"}, x_coord, 0);            chk({tag, "_y"}, y_coord, 0);
    chk({tag, "_active"}, active, 0);        chk({tag, "_locked"}, locked, 0);
    chk({tag, "_line_err"}, line_err, 0);    chk({tag, "_frame_err"}, frame_err, 0);
    chk({tag, "_err_count"}, err_count, 0);  chk({tag, "_frame_count"}, frame_count, 0);
    chk({tag, "_probe_rgb"}, probe_rgb, 0);  chk({tag, "_probe_valid"}, probe_valid, 0);
    chk({tag, "_frame_crc"}, frame_crc, 0);  chk({tag, "_crc_valid"}, crc_valid, 0);
  endtask

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int pvBase, leBase, feBase, cb;
    modelReset();
    #1 Reset_n = 1'b0;
    #1 chkAllZero("reset");
    chkOn = 1;
    repeat (3) idleTick();
    sendLine(7, 10, 13, 0);
    @(negedge Clk);
    Reset_n = 1'b1;
    sendLine(7, 13, TH, 0);
    for (int l = 8; l < TV; l++) sendLine(l, 0, TH, 0);

    sendFrame(TV, -1, 0);
    chk("unlocked_after_1st_vstart", locked, 0);
    pinLock = 1; sendFrame(TV, -1, 0); pinLock = 0;
    pinXY = 1; sendFrame(TV, -1, 0); pinXY = 0;
    chk("frame_count_nominal", frame_count, 1);
    chk("err_count_nominal", err_count, 0);

    pvBase = pvCount;
    sendFrame(TV, -1, 1);
    sendFrame(TV, -1, 1);
    chk("probe_pulses_two_frames", pvCount - pvBase, 2);
    chk("probe_rgb_marker", probe_rgb, 12'hF00);

    leBase = leCount;
    sendFrame(TV, 5, 1);
    chk("short_line_pulses", leCount - leBase, 1);
    chk("short_line_err_count", err_count, 1);
    chk("short_line_unlocked", locked, 0);
    sendFrame(TV, -1, 0);
    chk("acquire_not_locked", locked, 0);
    sendFrame(TV - 1, -1, 0);
    chk("relocked_after_short_line", locked, 1);
    chk("frame_count_relock", frame_count, 4);

    feBase = feCount;
    sendFrame(TV, -1, 0);
    chk("short_frame_pulses", feCount - feBase, 1);
    chk("short_frame_err_count", err_count, 2);
    chk("short_frame_unlocked", locked, 0);
    chk("short_frame_frame_count", frame_count, 5);
    sendFrame(TV, -1, 0);
    sendFrame(TV, -1, 0);
    chk("relocked_after_short_frame", locked, 1);
    chk("frame_count_held", frame_count, 5);

    cb = crcQ.size();
    sendFrame(TV, -1, 2);
    sendFrame(TV, -1, 2);
    sendFrame(TV, -1, 3);
    sendFrame(TV, -1, 0);
    chk("frame_count_crc_frames", frame_count, 9);
`ifdef VGA_MON_CRC_EN
    chk("crc_pulse_count", crcQ.size() - cb, 4);
    if (crcQ.size() - cb == 4) begin
      chk("crc_identical_frames", crcQ[cb + 1], crcQ[cb + 2]);
      chk("crc_flipped_differs", crcQ[cb + 3] != crcQ[cb + 2], 1);
    end
`else
    chk("crc_pulse_count", crcQ.size() - cb, 0);
`endif

    for (int l = 0; l < 5; l++) sendLine(l, 0, TH, 0);
    sendLine(5, 0, 9, 0);
    @(negedge Clk);
    #2 Reset_n = 1'b0;
    modelReset();
    #1 chkAllZero("midreset");
    repeat (3) @(posedge Clk);
    @(negedge Clk);
    Reset_n = 1'b1;
    sendLine(5, 9, TH, 0);
    for (int l = 6; l < TV; l++) sendLine(l, 0, TH, 0);
    sendFrame(TV, -1, 0);
    chk("midreset_acquire", locked, 0);
    sendFrame(TV, -1, 0);
    chk("midreset_relocked", locked, 1);
    chk("midreset_frame_count", frame_count, 0);
    chk("midreset_err_count", err_count, 0);

    repeat (2) idleTick();
    chkOn = 0;
    $display("[TB] %0d tests run, %0d failed", nTests, nFail);
    $finish;
  end
endmodule

// File: doc/vga_rx_monitor.md
Name: vga_rx_monitor

Overview:
- Receive-side counterpart of the vga_top VGA output. Samples hSync/vSync/vgaR/G/B at the pixel rate and recovers pixel coordinates.
- Checks line and frame timing against the 640x480@60 format and captures one probed pixel.
- Used in simulation benches and as an on-board self-check tap on vga_top's VGA pins.

Parameters:
- H_TOTAL, 800, pixel clocks per line
- V_TOTAL, 525, lines per frame
- H_BP, 144, pixels from hSync assertion to first active pixel (sync + back porch)
- H_ACTIVE, 640, active pixels per line
- V_BP, 35, lines from vSync assertion to first active line
- V_ACTIVE, 480, active lines per frame
- SYNC_POL, 0, asserted level of hSync/vSync (0 = active-low)

Ports:
- Clk  in  1  system clock (100 MHz)
- Reset_n  in  1  asynchronous reset, active-low
- pix_en  in  1  one-Clk strobe per pixel (Clk/4); inputs sampled only when high
- hSync  in  1  horizontal sync
- vSync  in  1  vertical sync
- vgaR, vgaG, vgaB  in  4 each  pixel colour
- probe_x  in  10  probe column (active coordinates)
- probe_y  in  10  probe row
- x_coord  out  10  recovered active column; 0 when not active
- y_coord  out  10  recovered active row; 0 when not active
- active  out  1  current sample is inside the active window and locked
- locked  out  1  timing lock achieved
- line_err  out  1  one-Clk pulse: bad line length
- frame_err  out  1  one-Clk pulse: bad frame length
- err_count  out  8  saturating error count
- frame_count  out  16  frames seen while locked, wraps
- probe_rgb  out  12  {R,G,B} captured at the probe coordinate
- probe_valid  out  1  one-Clk pulse on capture
- frame_crc  out  16  see Optional Feature
- crc_valid  out  1  see Optional Feature

Behaviour:
- Reset: all outputs and internal counters 0; FSM = SEARCH. Reset can be asserted at any time, including mid-frame.
- Sampling: all logic advances only on Clk edges with pix_en=1. Registered outputs update 1 Clk after the sampling edge.
- h leading edge (hEdge): sampled hSync equals SYNC_POL and the previous sample did not.
  - On hEdge: hcount <= 0.
  - Otherwise hcount increments, saturating at 1023.
  - On hEdge, if hcount+1 != H_TOTAL and FSM != SEARCH: pulse line_err.
- Vertical tracking is evaluated only on hEdge.
  - vStart: vSync sampled asserted on this hEdge and deasserted on the previous hEdge.
  - On vStart: vcount <= 0. Otherwise vcount increments, saturating at 1023.
  - On vStart, if vcount+1 != V_TOTAL and FSM != SEARCH: pulse frame_err.
- FSM:
  - SEARCH -> ACQUIRE on the first vStart.
  - ACQUIRE: on vStart with no line_err/frame_err since entry -> LOCKED. Any error restarts ACQUIRE at the next vStart.
  - LOCKED: any line_err or frame_err -> SEARCH. Each vStart increments frame_count.
- active: 1 when locked, H_BP <= hcount < H_BP+H_ACTIVE, and V_BP <= vcount < V_BP+V_ACTIVE.
  - When active: x_coord = hcount-H_BP, y_coord = vcount-V_BP.
  - Otherwise both are 0.
- Probe: when active and x/y equal probe_x/probe_y, probe_rgb <= {vgaR,vgaG,vgaB} and probe_valid pulses one Clk. probe_rgb holds until the next capture.
- Probe inputs may change at any time; they are sampled at the same edge as the pixel.
- err_count: +1 per Clk in which line_err or frame_err pulses; a simultaneous pair counts once. Saturates at 255.
- Sync polarity glitch shorter than one pix_en sample is not detected (documented limitation).

Optional Feature:
- Macro: VGA_MON_CRC_EN.
- Defined:
  - CRC-16-CCITT (poly 0x1021, init 0xFFFF) runs over the 12-bit {R,G,B} of every active pixel in raster order, MSB first.
  - At each vStart while LOCKED: frame_crc <= result, crc_valid pulses one Clk, CRC reinitialises.
- Undefined: frame_crc and crc_valid tied to 0; ports retained.

Test Plan:
- Nominal 640x480 stream with Reset_n released mid-line -> locked=0 through first vStart, locked=1 one Clk after the second vStart; x_coord=0,y_coord=0,active=1 at hcount=144,vcount=35; x=639,y=479 at last active pixel.
- probe_x=320, probe_y=240, pixel colour 12'hF00 there, 12'h000 elsewhere -> probe_rgb=12'hF00, exactly one probe_valid pulse per frame.
- While locked, one line of 799 pix_en samples -> single line_err pulse, locked=0, err_count=1; relock after two further clean vStarts.
- While locked, frame of 524 lines -> frame_err at vStart, err_count increments by 1, FSM returns to SEARCH; frame_count stops incrementing until relocked.
- Reset_n asserted mid-frame for 3 Clk -> all outputs 0 immediately (asynchronous); relock time identical to first scenario.
- VGA_MON_CRC_EN defined: two identical frames -> equal frame_crc values with crc_valid pulses; flip one pixel in the third frame -> frame_crc differs.
